// File: rtl/sdram_req_pkg.sv
// Shared types and constants for the sdram_* request master.
package sdram_req_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [15:0] wdata;
    } req_t;

    localparam logic [3:0]  BE_LO        = 4'b0011;
    localparam logic [3:0]  BE_HI        = 4'b1100;
    localparam logic [3:0]  BE_ALL       = 4'b1111;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Stores touch only the addressed half; loads always fetch the full word.
    function automatic logic [3:0] lane_be(input req_t r);
        if (!r.we)
            return BE_ALL;
        return r.addr[0] ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request queue of req_t entries; count-based full/empty.
module sdram_req_fifo
    import sdram_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    output logic full,
    output logic empty,
    input  req_t din,
    output req_t dout
);
    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sdram_req_master.sv
// Halfword CPU load/store queue issuing on the 32-bit sdram_* strobe/ack port.
// Optional ack timeout enabled by defining SDRAM_REQ_TIMEOUT_EN.
module sdram_req_master
    import sdram_req_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_we,
    input  logic [16:0] cpu_req_addr,
    input  logic [15:0] cpu_req_wdata,
    output logic        cpu_rsp_valid,
    output logic [15:0] cpu_rsp_rdata,
    output logic        cpu_rsp_err,
    output logic [15:0] sdram_address,
    output logic [3:0]  sdram_byte_enable,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [31:0] sdram_write_data,
    input  logic        sdram_acknowledge,
    input  logic [31:0] sdram_read_data
);
    state_t state;
    req_t   fifo_din, fifo_dout;
    logic   fifo_full, fifo_empty, pop;
    logic   cur_we, cur_half;

    assign cpu_req_ready = !fifo_full;
    assign fifo_din      = '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};
    assign pop           = (state == IDLE) && !fifo_empty;

    sdram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (cpu_req_valid),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .din   (fifo_din),
        .dout  (fifo_dout)
    );

`ifdef SDRAM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;
`else
    assign cpu_rsp_err = 1'b0;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state             <= IDLE;
            cur_we            <= 1'b0;
            cur_half          <= 1'b0;
            sdram_address     <= '0;
            sdram_byte_enable <= '0;
            sdram_read        <= 1'b0;
            sdram_write       <= 1'b0;
            sdram_write_data  <= '0;
            cpu_rsp_valid     <= 1'b0;
            cpu_rsp_rdata     <= '0;
`ifdef SDRAM_REQ_TIMEOUT_EN
            cpu_rsp_err       <= 1'b0;
            to_cnt            <= '0;
`endif
        end else begin
            cpu_rsp_valid <= 1'b0;
            case (state)
                IDLE: if (!fifo_empty) begin
                    cur_we            <= fifo_dout.we;
                    cur_half          <= fifo_dout.addr[0];
                    sdram_address     <= fifo_dout.addr[16:1];
                    sdram_byte_enable <= lane_be(fifo_dout);
                    sdram_write_data  <= fifo_dout.we ? {fifo_dout.wdata, fifo_dout.wdata} : 32'h0;
                    sdram_read        <= !fifo_dout.we;
                    sdram_write       <= fifo_dout.we;
                    state             <= ISSUE;
`ifdef SDRAM_REQ_TIMEOUT_EN
                    to_cnt            <= '0;
`endif
                end
                ISSUE: if (sdram_acknowledge) begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    sdram_read    <= 1'b0;
                    sdram_write   <= 1'b0;
                    cpu_rsp_valid <= 1'b1;
                    cpu_rsp_rdata <= cur_we   ? 16'h0 :
                                     cur_half ? sdram_read_data[31:16] : sdram_read_data[15:0];
`ifdef SDRAM_REQ_TIMEOUT_EN
                    cpu_rsp_err   <= 1'b0;
`endif
                    state         <= GAP;
                end
`ifdef SDRAM_REQ_TIMEOUT_EN
                else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    sdram_read    <= 1'b0;
                    sdram_write   <= 1'b0;
                    cpu_rsp_valid <= 1'b1;
                    cpu_rsp_rdata <= TIMEOUT_DATA;
                    cpu_rsp_err   <= 1'b1;
                    state         <= GAP;
                end else begin
                    to_cnt <= to_cnt + CW'(1);
                end
`endif
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_master.sv
// Bench for sdram_req_master: vector table, directed corner sequences, random scoreboard.
module tb_sdram_req_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [16:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata, s_addr;
    logic [3:0]  s_be;
    logic        s_rd, s_wr, s_ack = 1'b0;
    logic [31:0] s_wd, s_rdata = '0;

    int checks = 0, errors = 0;

    sdram_req_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .cpu_req_valid(req_valid), .cpu_req_ready(req_ready), .cpu_req_we(req_we),
        .cpu_req_addr(req_addr), .cpu_req_wdata(req_wdata),
        .cpu_rsp_valid(rsp_valid), .cpu_rsp_rdata(rsp_rdata), .cpu_rsp_err(rsp_err),
        .sdram_address(s_addr), .sdram_byte_enable(s_be), .sdram_read(s_rd),
        .sdram_write(s_wr), .sdram_write_data(s_wd),
        .sdram_acknowledge(s_ack), .sdram_read_data(s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // Reference model: lane rules written as plain arithmetic.
    function automatic logic [15:0] m_addr(input logic [16:0] a);
        return 16'(a >> 1);
    endfunction
    function automatic logic [3:0] m_be(input logic we, input logic [16:0] a);
        return we ? 4'(3 << (2 * int'(a[0]))) : 4'hF;
    endfunction
    function automatic logic [31:0] m_wd(input logic we, input logic [15:0] d);
        return we ? 32'(d) * 32'h0001_0001 : 32'h0;
    endfunction
    function automatic logic [15:0] m_rdata(input logic we, input logic [16:0] a, input logic [31:0] rd);
        return we ? 16'h0 : 16'(rd >> (16 * int'(a[0])));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic strobe();
        return s_rd | s_wr;
    endfunction

    task automatic push(input logic we, input logic [16:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int lows);
        lows = 0;
        while (!strobe() && lows < 20) begin
            step();
            lows++;
        end
        if (!strobe()) chk("strobe_wait_timeout", 32'(strobe()), 32'h1);
    endtask

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [15:0] wdata;
        logic [31:0] rd;
        int          lat;
        logic [15:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vt[5];

    task automatic run_vec(input vec_t v, input string tag);
        logic stable;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        chk({tag, "_ready"}, 32'(req_ready), 32'h1);
        step();
        req_valid = 1'b0;
        chk({tag, "_strobe_early"}, 32'(strobe()), 32'h0);
        step();
        chk({tag, "_strobe"}, {30'h0, s_wr, s_rd}, {30'h0, v.we, !v.we});
        chk({tag, "_addr"}, 32'(s_addr), 32'(v.e_addr));
        chk({tag, "_be"}, 32'(s_be), 32'(v.e_be));
        chk({tag, "_wdata"}, s_wd, v.e_wd);
        stable = 1'b1;
        for (int i = 0; i < v.lat; i++) begin
            step();
            if (s_addr !== v.e_addr || s_be !== v.e_be || s_wd !== v.e_wd ||
                s_wr !== v.we || s_rd !== !v.we || rsp_valid !== 1'b0) stable = 1'b0;
        end
        chk({tag, "_stable"}, 32'(stable), 32'h1);
        s_ack = 1'b1; s_rdata = v.rd;
        step();
        s_ack = 1'b0; s_rdata = $urandom;
        chk({tag, "_strobe_drop"}, 32'(strobe()), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(v.e_rdata));
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        step();
        chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'h0);
        step();
    endtask

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [15:0] wdata;
    } mreq_t;

    initial begin
        int    lows, n, wait_n, c;
        logic  seen_rsp, seen_strobe, in_txn;
        logic [31:0] rd;
        mreq_t req_q[$];
        logic [15:0] rsp_q[$];
        mreq_t cur;
        logic [15:0] e;

        vt[0] = '{1'b1, 17'h00003, 16'hBEEF, 32'h0,         3, 16'h0001, 4'b1100, 32'hBEEFBEEF, 16'h0000};
        vt[1] = '{1'b0, 17'h00010, 16'h0,    32'h1234_5678, 0, 16'h0008, 4'b1111, 32'h0,        16'h5678};
        vt[2] = '{1'b0, 17'h00011, 16'h0,    32'h1234_5678, 1, 16'h0008, 4'b1111, 32'h0,        16'h1234};
        vt[3] = '{1'b1, 17'h1FFFE, 16'h00A5, 32'h0,         2, 16'hFFFF, 4'b0011, 32'h00A500A5, 16'h0000};
        vt[4] = '{1'b0, 17'h1FFFF, 16'h0,    32'hCAFE_F00D, 0, 16'hFFFF, 4'b1111, 32'h0,        16'hCAFE};

        // Reset state
        step(); step();
        chk("rst_strobe", {30'h0, s_wr, s_rd}, 32'h0);
        chk("rst_outputs", {s_addr, 12'h0, s_be}, 32'h0);
        chk("rst_wdata", s_wd, 32'h0);
        chk("rst_rsp", {15'h0, rsp_valid, rsp_rdata}, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        rst = 1'b0;
        step();

        foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

        // Five loads against a stalled responder: queue fills, order and gap hold.
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h00100 + 17'(i);
            chk($sformatf("fill_ready%0d", i), 32'(req_ready), 32'h1);
            step();
        end
        req_addr = 17'h00777;
        chk("fill_full", 32'(req_ready), 32'h0);
        step();
        chk("fill_still_full", 32'(req_ready), 32'h0);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_strobe(lows);
            if (k > 0) chk($sformatf("fill_gap%0d", k), 32'(lows), 32'h2);
            chk($sformatf("fill_addr%0d", k), 32'(s_addr), 32'(m_addr(17'h00100 + 17'(k))));
            rd = {16'hA000 + 16'(k), 16'hB000 + 16'(k)};
            s_ack = 1'b1; s_rdata = rd;
            step();
            s_ack = 1'b0;
            chk($sformatf("fill_rsp%0d", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("fill_rdata%0d", k), 32'(rsp_rdata),
                32'(m_rdata(1'b0, 17'h00100 + 17'(k), rd)));
        end
        seen_strobe = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); if (strobe()) seen_strobe = 1'b1; end
        chk("fill_no_sixth", 32'(seen_strobe), 32'h0);
        chk("fill_ready_after", 32'(req_ready), 32'h1);

        // Reset while strobing with another request queued, then a stray ack.
        push(1'b1, 17'h00040, 16'h1111);
        push(1'b1, 17'h00042, 16'h2222);
        wait_strobe(lows);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobe", 32'(strobe()), 32'h0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_bus", {s_addr, 12'h0, s_be}, 32'h0);
        step();
        rst = 1'b0;
        step();
        s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
        step();
        s_ack = 1'b0;
        seen_rsp = 1'b0; seen_strobe = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen_rsp = 1'b1;
            if (strobe()) seen_strobe = 1'b1;
            step();
        end
        chk("stray_ack_rsp", 32'(seen_rsp), 32'h0);
        chk("flushed_no_strobe", 32'(seen_strobe), 32'h0);

        // Ack while idle is ignored and leaves the FSM usable.
        s_ack = 1'b1; s_rdata = 32'h0BAD_0BAD;
        step();
        s_ack = 1'b0;
        seen_rsp = 1'b0; seen_strobe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) seen_rsp = 1'b1;
            if (strobe()) seen_strobe = 1'b1;
            step();
        end
        chk("idle_ack_rsp", 32'(seen_rsp), 32'h0);
        chk("idle_ack_strobe", 32'(seen_strobe), 32'h0);
        run_vec(vt[2], "idle_after");

`ifdef SDRAM_REQ_TIMEOUT_EN
        push(1'b0, 17'h00020, 16'h0);
        wait_strobe(lows);
        n = 0;
        while (strobe() && n < 20) begin n++; step(); end
        chk("to_len", 32'(n), 32'h8);
        chk("to_rsp", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 32'h1);
        chk("to_rdata", 32'(rsp_rdata), 32'hDEAD);
        step(); step();
        push(1'b0, 17'h00021, 16'h0);
        wait_strobe(lows);
        for (int i = 1; i < 8; i++) step();
        chk("to_edge_hold", 32'(strobe()), 32'h1);
        s_ack = 1'b1; s_rdata = 32'h55AA_1234;
        step();
        s_ack = 1'b0;
        chk("to_edge_rsp", 32'(rsp_valid), 32'h1);
        chk("to_edge_err", 32'(rsp_err), 32'h0);
        chk("to_edge_rdata", 32'(rsp_rdata), 32'h55AA);
        step(); step();
`else
        push(1'b0, 17'h00020, 16'h0);
        wait_strobe(lows);
        n = 0;
        while (strobe() && n < 20) begin n++; step(); end
        chk("no_to_hold", 32'(n), 32'd20);
        s_ack = 1'b1; s_rdata = 32'h55AA_1234;
        step();
        s_ack = 1'b0;
        chk("no_to_rsp", 32'(rsp_valid), 32'h1);
        chk("no_to_err", 32'(rsp_err), 32'h0);
        chk("no_to_rdata", 32'(rsp_rdata), 32'h1234);
        step(); step();
`endif

        // Random traffic against a queue scoreboard.
        in_txn = 1'b0; wait_n = 0; c = 0;
        cur = '{1'b0, 17'h0, 16'h0};
        while ((c < 400 || req_q.size() != 0 || rsp_q.size() != 0 || in_txn) && c < 1500) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) chk("rnd_spurious_rsp", 32'h1, 32'h0);
                else begin
                    e = rsp_q.pop_front();
                    chk("rnd_rdata", 32'(rsp_rdata), 32'(e));
                    chk("rnd_err", 32'(rsp_err), 32'h0);
                end
            end
            s_ack = 1'b0;
            if (strobe()) begin
                if (!in_txn) begin
                    if (req_q.size() == 0) chk("rnd_spurious_strobe", 32'h1, 32'h0);
                    else begin
                        cur = req_q.pop_front();
                        in_txn = 1'b1;
                        wait_n = $urandom_range(0, 3);
                    end
                end
                if (in_txn) begin
                    chk("rnd_addr", 32'(s_addr), 32'(m_addr(cur.addr)));
                    chk("rnd_be_dir", {26'h0, s_be, s_wr, s_rd}, {26'h0, m_be(cur.we, cur.addr), cur.we, !cur.we});
                    chk("rnd_wdata", s_wd, m_wd(cur.we, cur.wdata));
                    if (wait_n == 0) begin
                        rd = $urandom;
                        s_ack = 1'b1; s_rdata = rd;
                        rsp_q.push_back(m_rdata(cur.we, cur.addr, rd));
                        in_txn = 1'b0;
                    end else wait_n--;
                end
            end else if (in_txn) chk("rnd_strobe_dropped", 32'h0, 32'h1);
            req_valid = 1'b0;
            if (c < 400 && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_we = 1'($urandom);
                req_addr = 17'($urandom);
                req_wdata = 16'($urandom);
                if (req_ready) req_q.push_back('{req_we, req_addr, req_wdata});
            end
            step();
            c++;
        end
        s_ack = 1'b0; req_valid = 1'b0;
        chk("rnd_drained_req", 32'(req_q.size()), 32'h0);
        chk("rnd_drained_rsp", 32'(rsp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
